sensor_poll_avg: RTL and testbench

Periodic sensor-poll sequencer with a moving-average filter. It sits between the CPU-side control logic and the SPI sensor peripheral. It pulses the peripheral's start/write-enable, waits for the peripheral busy flag to rise and fall, then captures the 8-bit sensor byte. Captured bytes go into a 2^AVG_LOG2-deep moving average for the rest of the system.

---
 rtl/sensor_poll_pkg.sv | 20 ++
 rtl/avg_window.sv | 61 ++++++
 rtl/sensor_poll_avg.sv | 193 +++++++++++++++++++
 tb/tb_sensor_poll_avg.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sensor_poll_pkg.sv
// Shared types and constants for the sensor poll sequencer.
package sensor_poll_pkg;

    // Poll sequencer states.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        CAPTURE = 3'd4,
        UPDATE  = 3'd5
    } poll_state_e;

    // Word written to the peripheral alongside the start strobe.
    localparam logic [31:0] START_WORD = 32'h0000_0001;

    // Width of the saturating captured-sample counter.
    localparam int unsigned COUNT_W = 16;

endpackage

// File: rtl/avg_window.sv
// Moving-average window: circular byte buffer, running sum and fill counter.
// avg_o only follows the sum once the window has been completely filled.
module avg_window #(
    parameter int unsigned AVG_LOG2 = 3
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic [7:0] din_i,
    input  logic       clr_i,
    output logic [7:0] avg_o,
    output logic       full_o
);
    localparam int          DEPTH    = 1 << AVG_LOG2;
    localparam int unsigned SUM_W    = 8 + AVG_LOG2;
    localparam int unsigned FILL_W   = AVG_LOG2 + 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(DEPTH);

    logic [7:0]          win_q [DEPTH];
    logic [AVG_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [7:0]          avg_q, avg_d;
    logic [7:0]          old_byte;

    // Next sum replaces the oldest slot; the sum width cannot overflow.
    always_comb begin
        old_byte = win_q[wr_ptr_q];
        sum_d    = sum_q - SUM_W'(old_byte) + SUM_W'(din_i);
        wr_ptr_d = wr_ptr_q + 1'b1;
        fill_d   = (fill_q == FILL_MAX) ? fill_q : fill_q + 1'b1;
        avg_d    = 8'(sum_d >> AVG_LOG2);
    end

    // Window state; clear takes priority over a coincident push.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
            fill_q   <= '0;
            avg_q    <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < DEPTH; i++) win_q[i] <= '0;
            wr_ptr_q <= '0;
            sum_q    <= '0;
            fill_q   <= '0;
            avg_q    <= '0;
        end else if (push_i) begin
            win_q[wr_ptr_q] <= din_i;
            wr_ptr_q        <= wr_ptr_d;
            sum_q           <= sum_d;
            fill_q          <= fill_d;
            if (fill_d == FILL_MAX) avg_q <= avg_d;
        end
    end

    assign avg_o  = avg_q;
    assign full_o = (fill_q == FILL_MAX);

endmodule

// File: rtl/sensor_poll_avg.sv
// Periodic sensor poll sequencer feeding a moving-average filter.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   IDLE    | waiting for a period tick
//   START   | strobe start_o next cycle, load timeout counter
//   WAIT_HI | waiting for the peripheral busy flag to rise
//   WAIT_LO | waiting for the peripheral busy flag to fall
//   CAPTURE | latch sample_i into last_o and the staging byte
//   UPDATE  | push the staged byte into the window, bump count_o
module sensor_poll_avg
    import sensor_poll_pkg::*;
#(
    parameter int unsigned PERIOD_CYC  = 1_000_000,
    parameter int unsigned TIMEOUT_CYC = 10_000,
    parameter int unsigned AVG_LOG2    = 3
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               clr_i,
    input  logic               busy_i,
    input  logic [7:0]         sample_i,
    output logic               start_o,
    output logic [31:0]        start_data_o,
    output logic [7:0]         last_o,
    output logic [7:0]         avg_o,
    output logic               avg_valid_o,
    output logic [COUNT_W-1:0] count_o,
    output logic               timeout_o,
    output logic               overrun_o
);
    localparam int unsigned      PER_W    = $clog2(PERIOD_CYC);
    localparam int unsigned      TO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [PER_W-1:0] PER_LOAD = PER_W'(PERIOD_CYC - 1);
    localparam logic [TO_W-1:0]  TO_LOAD  = TO_W'(TIMEOUT_CYC - 1);

    poll_state_e        state_q, state_d;
    logic [PER_W-1:0]   per_cnt_q, per_cnt_d;
    logic               tick_q, tick_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic               start_q, start_d;
    logic [7:0]         last_q, last_d;
    logic [7:0]         cap_q, cap_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               timeout_q, timeout_d;
    logic               overrun_q, overrun_d;
    logic               upd_q, upd_d;
    logic               capture, update, timeout_set, overrun_set;
    logic               win_full;

    // Period down-counter: parked at zero while disabled, so enabling ticks at once.
    always_comb begin
        per_cnt_d = per_cnt_q;
        tick_d    = 1'b0;
        if (!enable_i) begin
            per_cnt_d = '0;
        end else if (per_cnt_q == '0) begin
            tick_d    = 1'b1;
            per_cnt_d = PER_LOAD;
        end else begin
            per_cnt_d = per_cnt_q - 1'b1;
        end
    end

    // Sequencer next state; the timeout counter reloads at each busy edge it waits for.
    always_comb begin
        state_d     = state_q;
        to_cnt_d    = to_cnt_q;
        start_d     = 1'b0;
        capture     = 1'b0;
        update      = 1'b0;
        timeout_set = 1'b0;
        overrun_set = tick_q && (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (tick_q && enable_i) state_d = START;
            end
            START: begin
                start_d  = 1'b1;
                to_cnt_d = TO_LOAD;
                state_d  = WAIT_HI;
            end
            WAIT_HI: begin
                if (busy_i) begin
                    to_cnt_d = TO_LOAD;
                    state_d  = WAIT_LO;
                end else if (to_cnt_q == '0) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            WAIT_LO: begin
                if (!busy_i) begin
                    state_d = CAPTURE;
                end else if (to_cnt_q == '0) begin
                    timeout_set = 1'b1;
                    state_d     = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                capture = 1'b1;
                state_d = UPDATE;
            end
            UPDATE: begin
                update  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Result registers and sticky flags; clr_i overrides any same-cycle update.
    always_comb begin
        last_d    = last_q;
        cap_d     = cap_q;
        count_d   = count_q;
        timeout_d = timeout_q;
        overrun_d = overrun_q;
        upd_d     = 1'b0;
        if (capture) begin
            last_d = sample_i;
            cap_d  = sample_i;
        end
        if (update) begin
            upd_d = 1'b1;
            if (count_q != '1) count_d = count_q + 1'b1;
        end
        if (timeout_set) timeout_d = 1'b1;
        if (overrun_set) overrun_d = 1'b1;
        if (clr_i) begin
            last_d    = '0;
            count_d   = '0;
            timeout_d = 1'b0;
            overrun_d = 1'b0;
            upd_d     = 1'b0;
        end
    end

    // State register bank.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            per_cnt_q <= '0;
            tick_q    <= 1'b0;
            to_cnt_q  <= '0;
            start_q   <= 1'b0;
            last_q    <= '0;
            cap_q     <= '0;
            count_q   <= '0;
            timeout_q <= 1'b0;
            overrun_q <= 1'b0;
            upd_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            per_cnt_q <= per_cnt_d;
            tick_q    <= tick_d;
            to_cnt_q  <= to_cnt_d;
            start_q   <= start_d;
            last_q    <= last_d;
            cap_q     <= cap_d;
            count_q   <= count_d;
            timeout_q <= timeout_d;
            overrun_q <= overrun_d;
            upd_q     <= upd_d;
        end
    end

    avg_window #(
        .AVG_LOG2(AVG_LOG2)
    ) u_avg_window (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .push_i (update),
        .din_i  (cap_q),
        .clr_i  (clr_i),
        .avg_o  (avg_o),
        .full_o (win_full)
    );

    assign start_o      = start_q;
    assign start_data_o = START_WORD;
    assign last_o       = last_q;
    assign count_o      = count_q;
    assign timeout_o    = timeout_q;
    assign overrun_o    = overrun_q;
    assign avg_valid_o  = upd_q & win_full;

endmodule

// File: tb/tb_sensor_poll_avg.sv
// Directed-plus-random bench for sensor_poll_avg with a behavioural peripheral
// and a queue-based moving-average reference.
module tb_sensor_poll_avg;
    localparam int PERIOD  = 100;
    localparam int TIMEOUT = 20;
    localparam int LOG2    = 2;
    localparam int DEPTH   = 4;

    logic        clk_i    = 1'b0;
    logic        reset_i  = 1'b0;
    logic        enable_i = 1'b0;
    logic        clr_i    = 1'b0;
    logic        busy_i   = 1'b0;
    logic [7:0]  sample_i = 8'h00;
    logic        start_o;
    logic [31:0] start_data_o;
    logic [7:0]  last_o, avg_o;
    logic        avg_valid_o;
    logic [15:0] count_o;
    logic        timeout_o, overrun_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    sensor_poll_avg #(
        .PERIOD_CYC (PERIOD),
        .TIMEOUT_CYC(TIMEOUT),
        .AVG_LOG2   (LOG2)
    ) dut (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .enable_i    (enable_i),
        .clr_i       (clr_i),
        .busy_i      (busy_i),
        .sample_i    (sample_i),
        .start_o     (start_o),
        .start_data_o(start_data_o),
        .last_o      (last_o),
        .avg_o       (avg_o),
        .avg_valid_o (avg_valid_o),
        .count_o     (count_o),
        .timeout_o   (timeout_o),
        .overrun_o   (overrun_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    // Peripheral: busy rises 2 cycles after start_o and lasts 10 cycles.
    // sample_i carries junk except around the busy fall, so a mistimed read shows.
    bit         never_busy  = 1'b0;
    logic [7:0] next_sample = 8'h00;
    int         phase       = -1;
    int         fall_cyc    = 0;
    always @(negedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            phase  = -1;
            busy_i = 1'b0;
        end else if (start_o && !never_busy) begin
            phase    = 0;
            sample_i = 8'($urandom);
        end else if (phase >= 0) begin
            phase++;
            if (phase == 2) busy_i = 1'b1;
            if (phase == 12) begin
                busy_i   = 1'b0;
                sample_i = next_sample;
                fall_cyc = cyc;
            end
            if (phase == 14) begin
                sample_i = 8'($urandom);
                phase    = -1;
            end
        end
    end

    int valid_pulses = 0;
    int valid_cyc    = 0;
    int start_pulses = 0;
    always @(negedge clk_i) begin
        if (avg_valid_o) begin
            valid_pulses++;
            valid_cyc = cyc;
        end
        if (start_o) start_pulses++;
    end

    // Reference: last DEPTH samples, average only once DEPTH samples exist.
    int         ref_q[$];
    int         ref_count = 0;
    logic [7:0] ref_last  = 8'h00;

    function automatic int ref_avg();
        int s = 0;
        if (ref_q.size() < DEPTH) return 0;
        foreach (ref_q[i]) s += ref_q[i];
        return s / DEPTH;
    endfunction

    task automatic ref_push(input logic [7:0] s);
        ref_q.push_back(int'(s));
        if (ref_q.size() > DEPTH) void'(ref_q.pop_front());
        if (ref_count < 65535) ref_count++;
        ref_last = s;
    endtask

    task automatic ref_clear();
        ref_q.delete();
        ref_count = 0;
        ref_last  = 8'h00;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_ref(input string tag);
        check({tag, "_last"},  32'(last_o),  32'(ref_last));
        check({tag, "_count"}, 32'(count_o), 32'(ref_count));
        check({tag, "_avg"},   32'(avg_o),   32'(ref_avg()));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_start"},      32'(start_o),     0);
        check({tag, "_start_data"}, start_data_o,     32'h1);
        check({tag, "_last"},       32'(last_o),      0);
        check({tag, "_avg"},        32'(avg_o),       0);
        check({tag, "_valid"},      32'(avg_valid_o), 0);
        check({tag, "_count"},      32'(count_o),     0);
        check({tag, "_timeout"},    32'(timeout_o),   0);
        check({tag, "_overrun"},    32'(overrun_o),   0);
    endtask

    // Wait (bounded) for the next start_o; t is the cycle it was seen in.
    task automatic poll(input logic [7:0] s, output int t);
        int n = 0;
        next_sample = s;
        t = -1;
        while (n < 250 && t < 0) begin
            @(negedge clk_i);
            n++;
            if (start_o) t = cyc;
        end
        check("start_seen", 32'(t >= 0), 1);
    endtask

    task automatic settle();
        repeat (20) @(negedge clk_i);
    endtask

    int fill_vals[5] = '{10, 20, 30, 41, 1};

    initial begin
        int t_en, t_prev, t_s, sp0, vp0;
        logic [7:0] r;

        #1 reset_i = 1'b1;
        repeat (3) @(negedge clk_i);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        check("disabled_no_start", 32'(start_pulses), 0);

        // single poll
        enable_i = 1'b1;
        t_en = cyc;
        poll(8'h40, t_s);
        check("start_latency", 32'(t_s - t_en), 3);
        settle();
        ref_push(8'h40);
        check_ref("single");
        check("single_no_valid", 32'(valid_pulses), 0);
        t_prev = t_s;

        // clear while idle, then fill the window
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        ref_clear();
        check_ref("clr_idle");
        for (int i = 0; i < 5; i++) begin
            vp0 = valid_pulses;
            poll(8'(fill_vals[i]), t_s);
            check("fill_period", 32'(t_s - t_prev), PERIOD);
            t_prev = t_s;
            settle();
            ref_push(8'(fill_vals[i]));
            check_ref("fill");
            check("fill_valid_pulses", 32'(valid_pulses - vp0), 32'((ref_q.size() == DEPTH) ? 1 : 0));
            if (i == 3) check("fill_avg4", 32'(avg_o), 25);
            if (i >= 3) check("valid_latency", 32'(valid_cyc - fall_cyc), 3);
        end
        check("fill_avg5", 32'(avg_o), 23);

        // random samples
        for (int i = 0; i < 8; i++) begin
            r   = 8'($urandom);
            vp0 = valid_pulses;
            poll(r, t_s);
            check("rand_period", 32'(t_s - t_prev), PERIOD);
            t_prev = t_s;
            settle();
            ref_push(r);
            check_ref("rand");
            check("rand_valid_pulses", 32'(valid_pulses - vp0), 1);
        end

        // busy never rises
        never_busy = 1'b1;
        poll(8'h00, t_s);
        check("timeout_period", 32'(t_s - t_prev), PERIOD);
        t_prev = t_s;
        repeat (19) @(negedge clk_i);
        check("timeout_early", 32'(timeout_o), 0);
        @(negedge clk_i);
        check("timeout_set", 32'(timeout_o), 1);
        check("timeout_count", 32'(count_o), 32'(ref_count));
        never_busy = 1'b0;
        r = 8'($urandom);
        poll(r, t_s);
        check("timeout_next_start", 32'(t_s - t_prev), PERIOD);
        t_prev = t_s;
        settle();
        ref_push(r);
        check_ref("after_timeout");
        check("timeout_sticky", 32'(timeout_o), 1);

        // enable blip mid-transaction re-ticks while busy
        check("overrun_clear_before", 32'(overrun_o), 0);
        r = 8'($urandom);
        poll(r, t_s);
        check("overrun_period", 32'(t_s - t_prev), PERIOD);
        t_prev = t_s;
        repeat (5) @(negedge clk_i);
        enable_i = 1'b0;
        @(negedge clk_i);
        enable_i = 1'b1;
        repeat (14) @(negedge clk_i);
        ref_push(r);
        check_ref("overrun");
        check("overrun_set", 32'(overrun_o), 1);
        r = 8'($urandom);
        poll(r, t_s);
        check("overrun_no_extra_start", 32'(t_s - t_prev), PERIOD + 9);
        t_prev = t_s;
        settle();
        ref_push(r);
        check_ref("after_overrun");

        // disable mid-transaction: sample kept, no new start
        r = 8'($urandom);
        poll(r, t_s);
        check("disable_period", 32'(t_s - t_prev), PERIOD);
        repeat (5) @(negedge clk_i);
        enable_i = 1'b0;
        sp0 = start_pulses;
        repeat (200) @(negedge clk_i);
        ref_push(r);
        check_ref("disable_mid");
        check("disabled_start_count", 32'(start_pulses - sp0), 0);
        enable_i = 1'b1;
        t_en = cyc;
        r = 8'($urandom);
        poll(r, t_s);
        check("reenable_latency", 32'(t_s - t_en), 3);
        t_prev = t_s;
        settle();
        ref_push(r);
        check_ref("reenable");

        // clear coinciding with UPDATE
        r   = 8'($urandom);
        vp0 = valid_pulses;
        poll(r, t_s);
        check("clr_upd_period", 32'(t_s - t_prev), PERIOD);
        t_prev = t_s;
        while (cyc < t_s + 14) @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        repeat (8) @(negedge clk_i);
        ref_clear();
        check_ref("clr_update");
        check("clr_update_timeout", 32'(timeout_o), 0);
        check("clr_update_overrun", 32'(overrun_o), 0);
        check("clr_update_no_valid", 32'(valid_pulses - vp0), 0);
        for (int i = 0; i < DEPTH; i++) begin
            r   = 8'($urandom);
            vp0 = valid_pulses;
            poll(r, t_s);
            check("refill_period", 32'(t_s - t_prev), PERIOD);
            t_prev = t_s;
            settle();
            ref_push(r);
            check_ref("refill");
            check("refill_valid_pulses", 32'(valid_pulses - vp0), 32'((ref_q.size() == DEPTH) ? 1 : 0));
        end

        // reset while waiting for busy to fall
        r = 8'($urandom);
        poll(r, t_s);
        check("reset_period", 32'(t_s - t_prev), PERIOD);
        repeat (6) @(negedge clk_i);
        reset_i = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk_i);
        reset_i = 1'b0;
        t_en = cyc;
        ref_clear();
        r = 8'($urandom);
        poll(r, t_s);
        check("post_reset_latency", 32'(t_s - t_en), 3);
        settle();
        ref_push(r);
        check_ref("post_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
